// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues busy-wait imem reads and
// drives the IF/ID register, absorbing wait states, stalls and redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] NEXT_PC,
  input  logic        REDIRECT,
  input  logic        STALL,
  output logic [31:0] PC_PLUSFOUR,
  output logic [31:0] IMEM_ADDR,
  output logic        IMEM_READ,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  output logic [31:0] IFID_INSTR,
  output logic [31:0] IFID_PC,
  output logic        IFID_VALID
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HELD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t      state_q, state_n;
  logic [31:0] pc_q, pc_n;
  logic [31:0] redir_q, redir_n;
  logic [31:0] buf_q, buf_n;
  logic [31:0] instr_q, instr_n;
  logic [31:0] ifpc_q, ifpc_n;
  logic        valid_q, valid_n;

  logic [31:0] npc;
  logic        done;
  logic        unused_npc_lsb;

  // PC is always word aligned; the low bits of the mux output are dropped.
  assign npc            = {NEXT_PC[31:2], 2'b00};
  assign unused_npc_lsb = ^NEXT_PC[1:0];
  assign done           = !IMEM_BUSYWAIT;

  assign PC_PLUSFOUR = pc_q + 32'd4;
  assign IMEM_ADDR   = pc_q;
  assign IMEM_READ   = !RESET && (state_q != HELD);
  assign IFID_INSTR  = instr_q;
  assign IFID_PC     = ifpc_q;
  assign IFID_VALID  = valid_q;

  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    redir_n = redir_q;
    buf_n   = buf_q;
    instr_n = instr_q;
    ifpc_n  = ifpc_q;
    valid_n = valid_q;
    unique case (state_q)
      FETCH: begin
        unique case (1'b1)
          REDIRECT && done: begin
            pc_n    = npc;
            instr_n = NOP_INSTR;
            valid_n = 1'b0;
          end
          REDIRECT && !done: begin
            redir_n = npc;
            instr_n = NOP_INSTR;
            valid_n = 1'b0;
            state_n = DROP;
          end
          !REDIRECT && done && !STALL: begin
            instr_n = IMEM_READDATA;
            ifpc_n  = pc_q;
            valid_n = 1'b1;
            pc_n    = npc;
          end
          !REDIRECT && done && STALL: begin
            buf_n   = IMEM_READDATA;
            state_n = HELD;
          end
          !REDIRECT && !done && !STALL: begin
            valid_n = 1'b0;
          end
          default: ;
        endcase
      end
      HELD: begin
        unique case (1'b1)
          REDIRECT: begin
            pc_n    = npc;
            instr_n = NOP_INSTR;
            valid_n = 1'b0;
            state_n = FETCH;
          end
          !REDIRECT && !STALL: begin
            instr_n = buf_q;
            ifpc_n  = pc_q;
            valid_n = 1'b1;
            pc_n    = npc;
            state_n = FETCH;
          end
          default: ;
        endcase
      end
      DROP: begin
        // The stale read must finish at its original address before moving on.
        unique case (1'b1)
          done: begin
            pc_n    = REDIRECT ? npc : redir_q;
            state_n = FETCH;
          end
          !done && REDIRECT: begin
            redir_n = npc;
          end
          default: ;
        endcase
      end
      default: begin
        state_n = FETCH;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      redir_q <= 32'd0;
      buf_q   <= 32'd0;
      instr_q <= NOP_INSTR;
      ifpc_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      redir_q <= redir_n;
      buf_q   <= buf_n;
      instr_q <= instr_n;
      ifpc_q  <= ifpc_n;
      valid_q <= valid_n;
    end
  end

endmodule
